// File: rtl/nms_column_feeder.sv
// Buffers one raster frame, then streams 3-pixel vertical columns for the NMS window.
// Define NMS_FEED_BORDER_PAD_EN to insert zero pad columns (one leading, one after each row).
`ifndef BIT_LENGTH
`define BIT_LENGTH 5
`endif

module nms_column_feeder #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [`BIT_LENGTH-1:0] pixel_in,
  input  logic [1:0]             angle_in,
  output logic                   in_ready,
  output logic [`BIT_LENGTH-1:0] pixel_out0,
  output logic [`BIT_LENGTH-1:0] pixel_out1,
  output logic [`BIT_LENGTH-1:0] pixel_out2,
  output logic [1:0]             angle_out,
  output logic                   enable,
  output logic                   done
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
`ifdef NMS_FEED_BORDER_PAD_EN
  localparam int unsigned SLEN     = 1 + HEIGHT * (WIDTH + 1);
  localparam logic        PAD_INIT = 1'b1;
`else
  localparam int unsigned SLEN     = NPIX;
  localparam logic        PAD_INIT = 1'b0;
`endif
  localparam int IDX_W = $clog2(NPIX);
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam int COL_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(SLEN);

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [`BIT_LENGTH-1:0] mem_pix [NPIX];
  logic [1:0]             mem_ang [NPIX];

  logic [1:0]       state;
  logic [IDX_W-1:0] wr_idx;
  logic [ROW_W-1:0] nrow, adv_row;
  logic [COL_W-1:0] ncol, adv_col;
  logic             npad, adv_pad;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cur_ang;

  logic [`BIT_LENGTH-1:0] col0, col1, col2;
  logic [1:0]             col_ang;
  logic [IDX_W-1:0]       ctr;

  assign in_ready = (state == LOAD);

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (in_valid && state == LOAD) begin
      mem_pix[wr_idx] <= pixel_in;
      mem_ang[wr_idx] <= angle_in;
    end
  end

  // Column at the (nrow, ncol, npad) position that will be loaded next.
  always_comb begin
    col0    = '0;
    col1    = '0;
    col2    = '0;
    col_ang = '0;
    ctr     = IDX_W'(int'(nrow) * WIDTH + int'(ncol));
    if (!npad && nrow < ROW_W'(HEIGHT)) begin
      col1    = mem_pix[ctr];
      col_ang = mem_ang[ctr];
      if (nrow != '0)
        col0 = mem_pix[ctr - IDX_W'(WIDTH)];
      if (nrow != ROW_W'(HEIGHT - 1))
        col2 = mem_pix[ctr + IDX_W'(WIDTH)];
    end
  end

  always_comb begin
    adv_row = nrow;
    adv_col = ncol;
    adv_pad = 1'b0;
`ifdef NMS_FEED_BORDER_PAD_EN
    if (npad) begin
      adv_pad = 1'b0;
    end else if (ncol == COL_W'(WIDTH - 1)) begin
      adv_col = '0;
      adv_row = nrow + 1'b1;
      adv_pad = 1'b1;
    end else begin
      adv_col = ncol + 1'b1;
    end
`else
    if (ncol == COL_W'(WIDTH - 1)) begin
      adv_col = '0;
      adv_row = nrow + 1'b1;
    end else begin
      adv_col = ncol + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      wr_idx     <= '0;
      nrow       <= '0;
      ncol       <= '0;
      npad       <= PAD_INIT;
      cnt        <= '0;
      cur_ang    <= '0;
      pixel_out0 <= '0;
      pixel_out1 <= '0;
      pixel_out2 <= '0;
      angle_out  <= '0;
      enable     <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            wr_idx <= wr_idx + 1'b1;
            // The first column never depends on the pixel captured on this edge.
            if (wr_idx == IDX_W'(NPIX - 1)) begin
              state      <= STREAM;
              enable     <= 1'b1;
              cnt        <= '0;
              pixel_out0 <= col0;
              pixel_out1 <= col1;
              pixel_out2 <= col2;
              cur_ang    <= col_ang;
              nrow       <= adv_row;
              ncol       <= adv_col;
              npad       <= adv_pad;
            end
          end
        end
        STREAM: begin
          angle_out <= cur_ang;
          if (cnt == CNT_W'(SLEN - 1)) begin
            state      <= FLUSH;
            pixel_out0 <= '0;
            pixel_out1 <= '0;
            pixel_out2 <= '0;
          end else begin
            cnt        <= cnt + 1'b1;
            pixel_out0 <= col0;
            pixel_out1 <= col1;
            pixel_out2 <= col2;
            cur_ang    <= col_ang;
            nrow       <= adv_row;
            ncol       <= adv_col;
            npad       <= adv_pad;
          end
        end
        FLUSH: begin
          state     <= DONE;
          enable    <= 1'b0;
          done      <= 1'b1;
          angle_out <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nms_column_feeder.sv
// Self-checking bench for nms_column_feeder on a 4x3 frame against a queue-based column model.
`ifndef BIT_LENGTH
`define BIT_LENGTH 5
`endif

module tb_nms_column_feeder;

  localparam int BL = `BIT_LENGTH;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NP = W * H;
`ifdef NMS_FEED_BORDER_PAD_EN
  localparam int L = 1 + H * (W + 1);
`else
  localparam int L = W * H;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [BL-1:0] pixel_in = '0;
  logic [1:0]    angle_in = '0;
  logic          in_ready;
  logic [BL-1:0] pixel_out0, pixel_out1, pixel_out2;
  logic [1:0]    angle_out;
  logic          enable, done;

  int tests = 0;
  int fails = 0;

  logic [BL-1:0] fp [NP];
  logic [1:0]    fa [NP];
  logic [BL-1:0] q0 [$];
  logic [BL-1:0] q1 [$];
  logic [BL-1:0] q2 [$];
  logic [1:0]    qa [$];

  nms_column_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pixel_in(pixel_in),
    .angle_in(angle_in), .in_ready(in_ready), .pixel_out0(pixel_out0),
    .pixel_out1(pixel_out1), .pixel_out2(pixel_out2), .angle_out(angle_out),
    .enable(enable), .done(done)
  );

  always #5 clk = ~clk;

  task automatic set_pattern_frame();
    for (int i = 0; i < NP; i++) begin
      fp[i] = BL'(i);
      fa[i] = 2'(i % 4);
    end
  endtask

  task automatic set_random_frame();
    for (int i = 0; i < NP; i++) begin
      fp[i] = BL'($urandom);
      fa[i] = 2'($urandom);
    end
  endtask

  // Expected column sequence straight from the frame geometry.
  task automatic build_model();
    q0 = {}; q1 = {}; q2 = {}; qa = {};
`ifdef NMS_FEED_BORDER_PAD_EN
    q0.push_back('0); q1.push_back('0); q2.push_back('0); qa.push_back('0);
`endif
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        q0.push_back(r > 0 ? fp[(r - 1) * W + c] : '0);
        q1.push_back(fp[r * W + c]);
        q2.push_back(r < H - 1 ? fp[(r + 1) * W + c] : '0);
        qa.push_back(fa[r * W + c]);
      end
`ifdef NMS_FEED_BORDER_PAD_EN
      q0.push_back('0); q1.push_back('0); q2.push_back('0); qa.push_back('0);
`endif
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if ({pixel_out0, pixel_out1, pixel_out2} !== '0 || angle_out !== 2'd0) begin
      fails++;
      $display("FAIL %s data got=%h/%h/%h ang=%0d exp=0/0/0 ang=0", name,
               pixel_out0, pixel_out1, pixel_out2, angle_out);
    end
    tests++;
    if ({enable, done, in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL %s ctrl got en/done/rdy=%b%b%b exp=001", name, enable, done, in_ready);
    end
  endtask

  // Returns at cycle N (#1 after the edge capturing the last pixel).
  task automatic load_frame(input string name, input bit gaps);
    int acc = 0;
    int cyc = 0;
    bit take;
    while (acc < NP && cyc < 4 * NP + 10) begin
      in_valid = !(gaps && (cyc % 2 == 1));
      pixel_in = fp[acc];
      angle_in = fa[acc];
      if (cyc == 0) begin
        tests++;
        if (in_ready !== 1'b1 || enable !== 1'b0) begin
          fails++;
          $display("FAIL %s load_ctrl got rdy=%b en=%b exp rdy=1 en=0", name, in_ready, enable);
        end
      end
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) acc++;
      cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (acc != NP) begin
      fails++;
      $display("FAIL %s load_timeout accepted=%0d exp=%0d", name, acc, NP);
    end
  endtask

  task automatic check_stream(input string name, input int stop_k, input bit noise);
    int en_cnt = 0;
    logic [BL-1:0] e0, e1, e2;
    logic [1:0] ea;
    for (int k = 0; k < L + 4; k++) begin
      if (k == stop_k) begin
        in_valid = 1'b0;
        return;
      end
      e0 = (k < L) ? q0[k] : '0;
      e1 = (k < L) ? q1[k] : '0;
      e2 = (k < L) ? q2[k] : '0;
      ea = (k >= 1 && k <= L) ? qa[k - 1] : 2'd0;
      tests++;
      if ({pixel_out0, pixel_out1, pixel_out2} !== {e0, e1, e2}) begin
        fails++;
        $display("FAIL %s pix k=%0d got=%h/%h/%h exp=%h/%h/%h", name, k,
                 pixel_out0, pixel_out1, pixel_out2, e0, e1, e2);
      end
      tests++;
      if (angle_out !== ea) begin
        fails++;
        $display("FAIL %s angle k=%0d got=%0d exp=%0d", name, k, angle_out, ea);
      end
      tests++;
      if (enable !== (k <= L) || done !== (k > L) || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s ctrl k=%0d got en/done/rdy=%b%b%b exp=%b%b0", name, k,
                 enable, done, in_ready, k <= L, k > L);
      end
      if (enable === 1'b1) en_cnt++;
      if (noise) begin
        in_valid = 1'b1;
        pixel_in = BL'($urandom);
        angle_in = 2'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests++;
    if (en_cnt != L + 1) begin
      fails++;
      $display("FAIL %s enable_len got=%0d exp=%0d", name, en_cnt, L + 1);
    end
  endtask

  task automatic async_reset(input string name);
    #2 reset = 1'b1;
    #1 check_idle(name);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    check_idle("por");
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_idle("por_release");
  endtask

  task automatic test_pattern();
    set_pattern_frame();
    build_model();
    load_frame("pattern", 1'b0);
    check_stream("pattern", -1, 1'b0);
  endtask

  task automatic test_reset_from_done();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL done_before_reset got=%b exp=1", done);
    end
    async_reset("reset_from_done");
  endtask

  task automatic test_gaps();
    set_pattern_frame();
    build_model();
    load_frame("gaps", 1'b1);
    check_stream("gaps", -1, 1'b0);
    async_reset("reset_after_gaps");
  endtask

  task automatic test_ignore_input();
    set_random_frame();
    build_model();
    load_frame("ignore", 1'b0);
    check_stream("ignore", -1, 1'b1);
    async_reset("reset_after_ignore");
  endtask

  task automatic test_mid_reset();
    set_random_frame();
    build_model();
    load_frame("mid_a", 1'b0);
    check_stream("mid_a", 5, 1'b1);
    async_reset("mid_reset");
    set_random_frame();
    build_model();
    load_frame("mid_b", 1'b1);
    check_stream("mid_b", -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_reset_from_done();
    test_gaps();
    test_ignore_input();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
